// File: rtl/sync_down_counter_reload.sv
`default_nettype none
//============================================================================
// Module      : sync_down_counter_reload
// Description : Synchronous WIDTH-bit down counter with parallel load,
//               count enable, one-shot / auto-reload mode and a registered
//               terminal-count pulse. Used as a tick or timeout generator.
// Revision    : 1.0  initial release
//============================================================================
module sync_down_counter_reload #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             running,
    output logic             done
);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic [0:0]       r_state;
    logic             r_tc;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [0:0]       w_state_nxt;
    logic             w_tc_nxt;
    logic             w_q_is_zero;

    assign w_q_is_zero = (r_q == c_ZERO);

    // Next-state decode; priority is rst > load > en, rst handled in the flop.
    always_comb begin
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_state_nxt  = r_state;
        w_tc_nxt     = 1'b0;
        if (load) begin
            // A load always restarts counting and suppresses the decrement.
            w_q_nxt      = d;
            w_reload_nxt = d;
            w_state_nxt  = c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (en) begin
                        if (!w_q_is_zero) begin
                            // Pulse tc on the step that lands on zero.
                            w_q_nxt  = r_q - c_ONE;
                            w_tc_nxt = (r_q == c_ONE);
                        end else if (auto_reload) begin
                            // A zero reload value keeps q at 0 and pulses tc every step.
                            w_q_nxt  = r_reload;
                            w_tc_nxt = (r_reload == c_ZERO);
                        end else begin
                            w_state_nxt = c_ST_HALT;
                        end
                    end
                end
                default: begin
                    // HALT: hold at zero until a load or reset.
                    w_state_nxt = c_ST_HALT;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RESET_VAL;
            r_reload <= RESET_VAL;
            r_state  <= c_ST_RUN;
            r_tc     <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_state  <= w_state_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign zero    = w_q_is_zero;
    assign running = (r_state == c_ST_RUN);
    assign done    = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_sync_down_counter_reload.sv
`default_nettype none
//============================================================================
// Module      : tb_sync_down_counter_reload
// Description : Directed self-checking bench for sync_down_counter_reload
//               (WIDTH=3, RESET_VAL=7) with a queue-based scoreboard.
// Revision    : 1.0  initial release
//============================================================================
module tb_sync_down_counter_reload;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] d;
    logic       auto_reload;
    logic [2:0] q;
    logic       tc;
    logic       zero;
    logic       running;
    logic       done;

    typedef struct packed {
        logic [2:0] q;
        logic       tc;
        logic       zero;
        logic       running;
        logic       done;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int step_no = 0;
    int tc_seen = 0;

    // Reference model state
    int m_q;
    int m_rl;
    bit m_halt;
    bit m_tc;

    sync_down_counter_reload #(
        .WIDTH     (3),
        .RESET_VAL (3'd7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .d           (d),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .zero        (zero),
        .running     (running),
        .done        (done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, push the expectation,
    // then pop and compare after the edge.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic [2:0] dv, input logic ar);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        rst = r; load = l; en = e; d = dv; auto_reload = ar;
        if (r) begin
            m_q = 7; m_rl = 7; m_halt = 0; m_tc = 0;
        end else if (l) begin
            m_q = int'(dv); m_rl = int'(dv); m_halt = 0; m_tc = 0;
        end else if (m_halt || !e) begin
            m_tc = 0;
        end else if (m_q > 0) begin
            m_q = m_q - 1;
            m_tc = (m_q == 0);
        end else if (ar) begin
            m_q = m_rl;
            m_tc = (m_rl == 0);
        end else begin
            m_halt = 1; m_tc = 0;
        end
        ex.q = 3'(m_q);
        ex.tc = m_tc;
        ex.zero = (m_q == 0);
        ex.running = !m_halt;
        ex.done = m_halt;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        step_no++;
        got = '{q: q, tc: tc, zero: zero, running: running, done: done};
        if (tc === 1'b1) tc_seen++;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            ex = sb.pop_front();
            chk("q",       32'(got.q),       32'(ex.q));
            chk("tc",      32'(got.tc),      32'(ex.tc));
            chk("zero",    32'(got.zero),    32'(ex.zero));
            chk("running", 32'(got.running), 32'(ex.running));
            chk("done",    32'(got.done),    32'(ex.done));
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; d = 3'd0; auto_reload = 1'b0;
        m_q = 0; m_rl = 0; m_halt = 0; m_tc = 0;

        // Reset state
        step(1, 0, 0, 3'd0, 1);
        chk("reset_q",       32'(q),       32'd7);
        chk("reset_tc",      32'(tc),      32'd0);
        chk("reset_running", 32'(running), 32'd1);
        chk("reset_done",    32'(done),    32'd0);

        // Wrap count: 16 enabled steps give exactly two tc pulses
        tc_seen = 0;
        for (int i = 0; i < 16; i++) step(0, 0, 1, 3'd0, 1);
        chk("wrap_tc_pulses", 32'(tc_seen), 32'd2);
        chk("wrap_end_q",     32'(q),       32'd7);

        // One-shot from 3: 3,2,1,0 then halt, then 10 idle enabled cycles
        step(0, 1, 0, 3'd3, 0);
        tc_seen = 0;
        for (int i = 0; i < 14; i++) step(0, 0, 1, 3'd0, 0);
        chk("oneshot_tc_pulses", 32'(tc_seen), 32'd1);
        chk("oneshot_done",      32'(done),    32'd1);
        chk("oneshot_q",         32'(q),       32'd0);
        // Load leaves HALT
        step(0, 1, 0, 3'd5, 0);
        chk("reload_running", 32'(running), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 3'd0, 0);
        chk("reload_count_q", 32'(q), 32'd2);

        // Hold: from 6, en = 1,0,0,1 gives 5,5,5,4
        step(0, 1, 0, 3'd6, 1);
        tc_seen = 0;
        step(0, 0, 1, 3'd0, 1);
        step(0, 0, 0, 3'd0, 1);
        step(0, 0, 0, 3'd0, 1);
        step(0, 0, 1, 3'd0, 1);
        chk("hold_q",  32'(q),       32'd4);
        chk("hold_tc", 32'(tc_seen), 32'd0);

        // Load beats enable: no decrement on the load cycle
        step(0, 1, 1, 3'd2, 1);
        chk("load_priority_q", 32'(q), 32'd2);

        // Mid-count reset restores reload value 7
        step(0, 1, 0, 3'd5, 1);
        step(0, 0, 1, 3'd0, 1);
        step(1, 0, 1, 3'd0, 1);
        chk("midrst_q", 32'(q), 32'd7);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 3'd0, 1);
        chk("midrst_wrap_q", 32'(q), 32'd7);

        // Zero reload: tc on every enabled cycle, none when disabled
        step(0, 1, 0, 3'd0, 1);
        tc_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 3'd0, 1);
        chk("zero_reload_tc", 32'(tc_seen), 32'd4);
        step(0, 0, 0, 3'd0, 1);
        step(0, 0, 1, 3'd0, 0);
        chk("zero_reload_halt", 32'(done), 32'd1);
        chk("zero_reload_tc0",  32'(tc),   32'd0);

        // Reset from HALT
        step(1, 0, 0, 3'd0, 0);
        chk("halt_rst_running", 32'(running), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
